mil_rx_decoder_p: RTL
=====================

Name: mil_rx_decoder_p

Overview:
Parametrised MIL-STD-1553B Manchester II word receiver. It takes the transceiver's differential receive pair and detects the command/status or data sync. It decodes DATA_W data bits plus one odd-parity bit, re-aligning its bit timing on every mid-bit transition. It sits between the bus transceiver and the RT/BC protocol logic, and adds Manchester-error detection and back-to-back word reception.

Parameters:
CLK_PER_BIT, 16, iCLK cycles per bus bit; even, >= 8 (16 = 16 MHz at 1 Mbit/s).
DATA_W, 16, data bits per word.
TOL, CLK_PER_BIT/4, allowed +/- deviation in cycles of any expected transition.

Ports:
iCLK  in  1  clock
iRESET  in  1  reset
iDI  in  2  receive pair; [1]=positive rail, [0]=negative rail
oDATA  out  DATA_W  last received word, MSB first on the bus
oCD  out  1  1 = command/status sync, 0 = data sync
oDONE  out  1  one-cycle strobe; oDATA/oCD/oPARITY_ERROR valid from this cycle
oPARITY_ERROR  out  1  odd parity over data+parity failed
oMAN_ERROR  out  1  one-cycle strobe; word aborted by a Manchester or line error
oBUSY  out  1  high from sync acceptance until oDONE or oMAN_ERROR

Behaviour:
- Reset: iRESET, asynchronous, active-high; clock iCLK. All outputs reset to 0; FSM goes to IDLE.
- Line decode: 2-FF synchroniser per rail. iDI=10 gives line=1, 01 gives line=0, 00/11 gives invalid. HALF=CLK_PER_BIT/2.
- IDLE: on the first valid level following invalid, start the phase counter. A transition at 3*HALF +/- TOL means sync accepted; oCD=1 if the first level was 1. Invalid, or no transition by 3*HALF+TOL, returns to HUNT/IDLE.
- SYNC2: the next mid-bit transition (bit 0) is expected at 2*CLK_PER_BIT +/- TOL after the sync transition.
- DATA: for each bit k (0..DATA_W, where DATA_W is parity):
  - First-half sample at expected_mid - HALF/2.
  - Second-half sample at expected_mid + HALF/2.
  - Bit value = first-half sample.
  - Samples must differ, and a transition must occur within expected_mid +/- TOL. The counter realigns to the actual transition cycle; the next expected_mid is CLK_PER_BIT later.
- Error: equal half samples, a missing transition, or invalid line → oMAN_ERROR pulse for 1 cycle, go to IDLE. oDATA is not updated and oDONE is not pulsed.
- Complete: the cycle after the parity bit's second-half sample:
  - oDONE=1 for 1 cycle.
  - oDATA and oCD are updated.
  - oPARITY_ERROR = ~^(data, parity), held until the next oDONE.
  - Go to GAP.
- GAP: a sync transition at 2*CLK_PER_BIT +/- TOL after the parity mid-bit means a contiguous next word is accepted (→ SYNC2). Otherwise, once the line is invalid for >= HALF, go to IDLE.
- Bit order: the first received data bit goes to oDATA[DATA_W-1].
- Counter widths: $clog2(3*CLK_PER_BIT) bits; no wrap permitted. The counter saturates in IDLE.
- Reset mid-word: immediate abort, no strobes.

Optional Feature:
MIL_RX_GLITCH_FILTER_EN
- Defined: 3-sample majority filter on the decoded line and valid flag after the synchroniser. Single-cycle glitches are rejected; latency increases by 2 cycles and timing is unaffected.
- Undefined: synchroniser output is used directly.

Decomposition:
- Package mil_pkg: FSM state enum (IDLE, SYNC2, DATA, GAP), sync polarity constants (SYNC_CMD=1'b1, SYNC_DATA=1'b0), and a function deriving HALF and the counter width from CLK_PER_BIT.
- Sub-module mil_line_conditioner: synchroniser, optional majority filter, and line/valid/edge outputs.

Test Plan:
- Command sync + 0xA5C3 + parity 1, CLK_PER_BIT=16 → oDONE pulse, oDATA=0xA5C3, oCD=1, oPARITY_ERROR=0, oMAN_ERROR=0.
- Data sync + 0x0000 + parity 1 → oCD=0, no error. Repeat with parity 0 → oPARITY_ERROR=1.
- Bit 5 sent without mid-bit transition → oMAN_ERROR pulse ~bit 5 + HALF/2, no oDONE, oBUSY falls. A following valid word decodes.
- Command + two data words with no gap → three oDONE pulses with oCD = 1, 0, 0 and correct oDATA each.
- Every bit edge jittered +/-3 cycles (TOL=4) → correct decode. Sync first level 3*HALF+6 → ignored, no strobes.
- iRESET pulse during bit 9 → all outputs 0 immediately. The next word decodes normally.

Source files
------------

// File: rtl/mil_pkg.sv
// mil_pkg: shared types and timing helpers for the 1553 receiver.
// FSM encoding, sync polarity and derived counter geometry.
package mil_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC2,
    DATA,
    GAP
  } mil_state_t;

  localparam logic SYNC_CMD  = 1'b1;
  localparam logic SYNC_DATA = 1'b0;

  function automatic int mil_half(input int cpb);
    return cpb / 2;
  endfunction

  function automatic int mil_cnt_w(input int cpb);
    return $clog2(3 * cpb);
  endfunction

  function automatic logic mil_maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mil_line_conditioner.sv
// mil_line_conditioner: rail synchroniser and line/valid/edge decode.
// MIL_RX_GLITCH_FILTER_EN adds a 3-sample majority vote (+2 cycles).
module mil_line_conditioner
  import mil_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic [1:0] i_di,
  output logic       o_line,
  output logic       o_valid,
  output logic       o_edge
);

  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic       r_pl;
  logic       r_pv;
  logic       w_raw_line;
  logic       w_raw_valid;
  logic       w_line;
  logic       w_valid;

  // two-flop synchroniser on both rails
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_di;
      r_s2 <= r_s1;
    end
  end

  assign w_raw_line  = r_s2[1];
  assign w_raw_valid = r_s2[1] ^ r_s2[0];

`ifdef MIL_RX_GLITCH_FILTER_EN
  logic [1:0] r_hl;
  logic [1:0] r_hv;
  logic       r_fl;
  logic       r_fv;

  // majority of the last three samples rejects 1-cycle glitches
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_hl <= '0;
      r_hv <= '0;
      r_fl <= 1'b0;
      r_fv <= 1'b0;
    end else begin
      r_hl <= {r_hl[0], w_raw_line};
      r_hv <= {r_hv[0], w_raw_valid};
      r_fl <= mil_maj3(w_raw_line, r_hl[0], r_hl[1]);
      r_fv <= mil_maj3(w_raw_valid, r_hv[0], r_hv[1]);
    end
  end

  assign w_line  = r_fl;
  assign w_valid = r_fv;
`else
  assign w_line  = w_raw_line;
  assign w_valid = w_raw_valid;
`endif

  // previous-cycle copy for transition detection
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_pl <= 1'b0;
      r_pv <= 1'b0;
    end else begin
      r_pl <= w_line;
      r_pv <= w_valid;
    end
  end

  assign o_line  = w_line;
  assign o_valid = w_valid;
  assign o_edge  = w_valid & r_pv & (w_line ^ r_pl);

endmodule

// File: rtl/mil_rx_decoder_p.sv
// mil_rx_decoder_p: 1553B Manchester II word receiver with realignment.
// Build option MIL_RX_GLITCH_FILTER_EN enables the line majority filter.
module mil_rx_decoder_p
  import mil_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_W      = 16,
  parameter int TOL         = CLK_PER_BIT / 4
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [1:0]        iDI,
  output logic [DATA_W-1:0] oDATA,
  output logic              oCD,
  output logic              oDONE,
  output logic              oPARITY_ERROR,
  output logic              oMAN_ERROR,
  output logic              oBUSY
);

  localparam int H  = mil_half(CLK_PER_BIT);
  localparam int Q  = H / 2;
  localparam int CW = mil_cnt_w(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [BW-1:0] bit_t;

  localparam cnt_t C_ONE   = cnt_t'(1);
  localparam cnt_t C_MAX   = cnt_t'((1 << CW) - 1);
  localparam cnt_t C_SY_LO = cnt_t'(3 * H - TOL);
  localparam cnt_t C_SY_HI = cnt_t'(3 * H + TOL);
  localparam cnt_t C_B0_LO = cnt_t'(2 * CLK_PER_BIT - TOL);
  localparam cnt_t C_B0_HI = cnt_t'(2 * CLK_PER_BIT + TOL);
  localparam cnt_t C_B0_S1 = cnt_t'(2 * CLK_PER_BIT - Q);
  localparam cnt_t C_BN_LO = cnt_t'(CLK_PER_BIT - TOL);
  localparam cnt_t C_BN_HI = cnt_t'(CLK_PER_BIT + TOL);
  localparam cnt_t C_BN_S1 = cnt_t'(CLK_PER_BIT - Q);
  localparam cnt_t C_S2    = cnt_t'(Q);
  localparam cnt_t C_H1    = cnt_t'(H - 1);
  localparam bit_t C_LAST  = bit_t'(DATA_W);
  localparam bit_t C_BONE  = bit_t'(1);

  mil_state_t        r_state;
  cnt_t              r_cnt;
  cnt_t              r_icnt;
  bit_t              r_bit;
  logic [DATA_W-1:0] r_sh;
  logic              r_s1;
  logic              r_got;
  logic              r_hunt;
  logic              r_cd;

  logic w_line;
  logic w_valid;
  logic w_edge;
  logic w_b0;
  logic w_bit_st;
  cnt_t w_lo;
  cnt_t w_hi;
  cnt_t w_s1;
  logic w_win;
  logic w_swin;
  logic w_gwin;
  logic w_bitv;
  logic w_miss;
  logic w_bad;
  logic w_abort;
  logic w_pol;

  mil_line_conditioner u_cond (
    .iCLK    (iCLK),
    .iRESET  (iRESET),
    .i_di    (iDI),
    .o_line  (w_line),
    .o_valid (w_valid),
    .o_edge  (w_edge)
  );

  assign w_b0     = (r_state == SYNC2);
  assign w_bit_st = (r_state == SYNC2) || (r_state == DATA);
  assign w_lo     = w_b0 ? C_B0_LO : C_BN_LO;
  assign w_hi     = w_b0 ? C_B0_HI : C_BN_HI;
  assign w_s1     = w_b0 ? C_B0_S1 : C_BN_S1;
  assign w_win    = (r_cnt >= w_lo) && (r_cnt <= w_hi);
  assign w_swin   = (r_cnt >= C_SY_LO) && (r_cnt <= C_SY_HI);
  assign w_gwin   = (r_cnt >= C_B0_LO) && (r_cnt <= C_B0_HI);
  assign w_bitv   = w_edge ? ~w_line : w_line;
  assign w_pol    = w_line ? SYNC_DATA : SYNC_CMD;
  assign w_miss   = !r_got && !(w_edge && w_win)
                    && (r_cnt >= w_hi);
  assign w_bad    = r_got && (r_cnt == C_S2)
                    && (w_bitv == r_s1);
  assign w_abort  = w_bit_st
                    && (!w_valid || w_miss || w_bad);

  // receive FSM: sync hunt, per-bit sampling, gap handling
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_icnt        <= '0;
      r_bit         <= '0;
      r_sh          <= '0;
      r_s1          <= 1'b0;
      r_got         <= 1'b0;
      r_hunt        <= 1'b0;
      r_cd          <= 1'b0;
      oDATA         <= '0;
      oCD           <= 1'b0;
      oDONE         <= 1'b0;
      oPARITY_ERROR <= 1'b0;
      oMAN_ERROR    <= 1'b0;
      oBUSY         <= 1'b0;
    end else begin
      oDONE      <= 1'b0;
      oMAN_ERROR <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_valid) begin
            r_hunt <= 1'b1;
            r_cnt  <= '0;
          end else if (r_hunt && w_edge && w_swin) begin
            r_state <= SYNC2;
            r_cd    <= w_pol;
            r_cnt   <= C_ONE;
            r_bit   <= '0;
            r_got   <= 1'b0;
            r_hunt  <= 1'b0;
            oBUSY   <= 1'b1;
          end else begin
            if (w_edge || (r_cnt > C_SY_HI)) r_hunt <= 1'b0;
            if (r_cnt != C_MAX) r_cnt <= r_cnt + C_ONE;
          end
        end
        SYNC2, DATA: begin
          if (w_abort) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_got      <= 1'b0;
            r_hunt     <= 1'b0;
            oMAN_ERROR <= 1'b1;
            oBUSY      <= 1'b0;
          end else if (!r_got) begin
            if (r_cnt == w_s1) r_s1 <= w_bitv;
            if (w_edge && w_win) begin
              r_got <= 1'b1;
              r_cnt <= C_ONE;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end else begin
            r_cnt <= r_cnt + C_ONE;
            if (r_cnt == C_S2) begin
              r_got <= 1'b0;
              if (r_bit == C_LAST) begin
                r_state       <= GAP;
                r_icnt        <= '0;
                oDONE         <= 1'b1;
                oDATA         <= r_sh;
                oCD           <= r_cd;
                oPARITY_ERROR <= ~^{r_sh, r_s1};
                oBUSY         <= 1'b0;
              end else begin
                r_state <= DATA;
                r_bit   <= r_bit + C_BONE;
                r_sh    <= {r_sh[DATA_W-2:0], r_s1};
              end
            end
          end
        end
        GAP: begin
          if (w_edge && w_gwin) begin
            r_state <= SYNC2;
            r_cd    <= w_pol;
            r_cnt   <= C_ONE;
            r_bit   <= '0;
            r_got   <= 1'b0;
            oBUSY   <= 1'b1;
          end else if ((r_cnt > C_B0_HI)
                       || (!w_valid && (r_icnt == C_H1))) begin
            r_state <= IDLE;
            r_hunt  <= !w_valid;
            r_cnt   <= '0;
          end else begin
            r_cnt  <= r_cnt + C_ONE;
            r_icnt <= w_valid ? '0 : r_icnt + C_ONE;
          end
        end
      endcase
    end
  end

endmodule
